// File: rtl/bram_stream_reader.sv
// Reads a block of words from a PL-side BRAM port after the PS hands it over
// and emits them as a valid/ready stream with full throughput and lossless backpressure.
module bram_stream_reader #(
  parameter int BRAM_DATA_WIDTH = 16,
  parameter int BRAM_ADDR_WIDTH = 10
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       ps_done,
  input  logic [BRAM_ADDR_WIDTH:0]   num_words,
  output logic                       bram_en,
  output logic                       bram_we,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_addr,
  input  logic [BRAM_DATA_WIDTH-1:0] bram_dout,
  output logic [BRAM_DATA_WIDTH-1:0] m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       m_last,
  output logic                       busy,
  output logic                       done
);

  localparam int DW = BRAM_DATA_WIDTH;
  localparam int AW = BRAM_ADDR_WIDTH;
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state;
  logic          ps_done_q;
  logic [AW:0]   target_m1;
  logic [AW-1:0] addr;

  logic          inflight;
  logic [AW-1:0] inflight_idx;

  logic [DW-1:0] fifo_data [2];
  logic [AW-1:0] fifo_idx  [2];
  logic          rd_ptr;
  logic          wr_ptr;
  logic [1:0]    cnt;

  logic          start;
  logic          abort;
  logic          pop;
  logic          push;
  logic          credit;
  logic          issue;
  logic          last_issue;
  logic [AW:0]   clamped;
  logic [AW:0]   clamped_m1;
  logic [2:0]    outstanding;

  always_comb begin
    start       = ps_done & ~ps_done_q;
    abort       = ~ps_done & ((state == S_RUN) | (state == S_DRAIN));
    clamped     = (num_words > DEPTH) ? DEPTH : num_words;
    clamped_m1  = clamped - (AW + 1)'(1);
    m_valid     = (cnt != 2'd0);
    m_data      = fifo_data[rd_ptr];
    pop         = m_valid & m_ready;
    push        = inflight;
    // Words already in the FIFO plus the one in flight must never exceed the two slots,
    // unless a pop this cycle frees one.
    outstanding = {1'b0, cnt} + {2'b00, inflight};
    credit      = (outstanding <= 3'd1) | ((outstanding == 3'd2) & pop);
    issue       = (state == S_RUN) & credit;
    last_issue  = issue & ({1'b0, addr} == target_m1);
    m_last      = m_valid & ({1'b0, fifo_idx[rd_ptr]} == target_m1);
  end

  assign bram_en   = issue;
  assign bram_we   = 1'b0;
  assign bram_addr = addr;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= S_IDLE;
      ps_done_q <= 1'b0;
      target_m1 <= '0;
      addr      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      ps_done_q <= ps_done;
      case (state)
        S_IDLE: begin
          if (start) begin
            addr      <= '0;
            target_m1 <= clamped_m1;
            if (clamped == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_RUN;
              busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (!ps_done) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (issue) begin
            addr <= addr + AW'(1);
            if (last_issue) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!ps_done) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if ((cnt == 2'd0) && !inflight) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          if (!ps_done) begin
            state <= S_IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Abort drops the in-flight read and everything queued; stale BRAM data is never pushed.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt          <= '0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      inflight     <= 1'b0;
      inflight_idx <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_idx[i]  <= '0;
      end
    end else if (abort) begin
      cnt      <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) inflight_idx <= addr;
      if (push) begin
        fifo_data[wr_ptr] <= bram_dout;
        fifo_idx[wr_ptr]  <= inflight_idx;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  fifo_no_overflow: assert property (@(posedge aclk) disable iff (!aresetn)
    !(push && !pop && !abort && (cnt == 2'd2)));

endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench for bram_stream_reader: BRAM model with one-cycle read latency,
// expected words queued at pass start and compared on each stream handshake.
module tb_bram_stream_reader;

  localparam int DW    = 16;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b1;
  logic          ps_done = 1'b0;
  logic [AW:0]   num_words = '0;
  logic          bram_en;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_dout = '0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          m_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [DEPTH];
  exp_t          sb [$];
  int            checks = 0;
  int            errors = 0;
  int            en_count = 0;
  logic [AW-1:0] last_addr = '0;

  bram_stream_reader #(
    .BRAM_DATA_WIDTH(DW),
    .BRAM_ADDR_WIDTH(AW)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .ps_done   (ps_done),
    .num_words (num_words),
    .bram_en   (bram_en),
    .bram_we   (bram_we),
    .bram_addr (bram_addr),
    .bram_dout (bram_dout),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    if (bram_en) begin
      bram_dout <= mem[bram_addr];
      last_addr <= bram_addr;
      en_count  <= en_count + 1;
    end
  end

  task automatic push_expected(input int n);
    int tgt;
    exp_t e;
    tgt = (n > DEPTH) ? DEPTH : n;
    for (int i = 0; i < tgt; i++) begin
      e.data = mem[i];
      e.last = (i == tgt - 1);
      sb.push_back(e);
    end
  endtask

  task automatic start_pass(input int n);
    @(posedge aclk); #1;
    num_words = (AW + 1)'(n);
    ps_done   = 1'b1;
  endtask

  task automatic end_pass();
    @(posedge aclk); #1;
    ps_done = 1'b0;
    @(posedge aclk); #1;
  endtask

  task automatic test_reset();
    #1 aresetn = 1'b0;
    #2;
    checks++;
    if ({bram_en, bram_we, bram_addr, m_data, m_valid, m_last, busy, done} !== '0)
      $display("FAIL reset_outputs: got en=%b we=%b addr=%h data=%h valid=%b last=%b busy=%b done=%b, expected all 0",
               bram_en, bram_we, bram_addr, m_data, m_valid, m_last, busy, done);
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
  endtask

  task automatic test_basic();
    logic exp_valid, exp_en, exp_busy, exp_done, exp_last;
    exp_t e;
    push_expected(4);
    m_ready = 1'b1;
    start_pass(4);
    for (int k = 0; k < 10; k++) begin
      @(posedge aclk);
      @(negedge aclk);
      exp_valid = (k >= 2) && (k <= 5);
      exp_en    = (k <= 3);
      exp_busy  = (k <= 6);
      exp_done  = (k >= 7);
      exp_last  = (k == 5);
      checks++;
      if (m_valid !== exp_valid) begin
        errors++; $display("FAIL basic_valid k=%0d: got %b, expected %b", k, m_valid, exp_valid);
      end
      checks++;
      if (bram_en !== exp_en) begin
        errors++; $display("FAIL basic_bram_en k=%0d: got %b, expected %b", k, bram_en, exp_en);
      end
      checks++;
      if ({busy, done} !== {exp_busy, exp_done}) begin
        errors++; $display("FAIL basic_busy_done k=%0d: got %b%b, expected %b%b", k, busy, done, exp_busy, exp_done);
      end
      checks++;
      if (m_last !== exp_last) begin
        errors++; $display("FAIL basic_last k=%0d: got %b, expected %b", k, m_last, exp_last);
      end
      if (m_valid === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (m_data !== e.data) begin
          errors++; $display("FAIL basic_data k=%0d: got %h, expected %h", k, m_data, e.data);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL basic_count: %0d words not delivered, expected 0", sb.size());
      sb.delete();
    end
    end_pass();
    @(negedge aclk);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL basic_done_clear: got %b, expected 0", done);
    end
  endtask

  task automatic test_backpressure();
    int   got = 0;
    int   stall = 0;
    int   issued0;
    int   outs;
    bit   prev_stall = 0;
    bit   saw_done = 0;
    logic [DW-1:0] prev_data = '0;
    exp_t e;
    issued0 = en_count;
    push_expected(8);
    m_ready = 1'b1;
    start_pass(8);
    for (int c = 0; c < 80 && !saw_done; c++) begin
      @(posedge aclk); #1;
      if (stall > 0) begin m_ready = 1'b0; stall--; end
      else m_ready = 1'b1;
      @(negedge aclk);
      outs = en_count - issued0 - got;
      checks++;
      if (outs > 2) begin
        errors++; $display("FAIL bp_outstanding c=%0d: got %0d, expected <= 2", c, outs);
      end
      if (m_valid && !m_ready && outs == 2) begin
        checks++;
        if (bram_en !== 1'b0) begin
          errors++; $display("FAIL bp_bram_en c=%0d: got %b, expected 0", c, bram_en);
        end
      end
      if (prev_stall) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== prev_data) begin
          errors++; $display("FAIL bp_hold c=%0d: got valid=%b data=%h, expected valid=1 data=%h", c, m_valid, m_data, prev_data);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL bp_extra c=%0d: got word %h, expected none", c, m_data);
        end else begin
          e = sb.pop_front();
          if (m_data !== e.data || m_last !== e.last) begin
            errors++; $display("FAIL bp_word c=%0d: got %h/%b, expected %h/%b", c, m_data, m_last, e.data, e.last);
          end
        end
        got++;
        if (got == 1) stall = 5;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      saw_done   = (done === 1'b1);
    end
    checks++;
    if (!saw_done || got != 8) begin
      errors++; $display("FAIL bp_complete: got done=%b words=%0d, expected done=1 words=8", saw_done, got);
    end
    sb.delete();
    end_pass();
  endtask

  task automatic test_zero();
    push_expected(0);
    start_pass(0);
    for (int k = 0; k < 5; k++) begin
      @(posedge aclk);
      @(negedge aclk);
      checks++;
      if ({done, busy, m_valid, bram_en} !== 4'b1000) begin
        errors++; $display("FAIL zero k=%0d: got done=%b busy=%b valid=%b en=%b, expected 1 0 0 0", k, done, busy, m_valid, bram_en);
      end
    end
    end_pass();
  endtask

  task automatic test_clamp();
    int   got = 0;
    int   issued0;
    bit   saw_done = 0;
    exp_t e;
    issued0 = en_count;
    push_expected(2047);
    m_ready = 1'b1;
    start_pass(2047);
    for (int c = 0; c < 5000 && !saw_done; c++) begin
      @(posedge aclk); #1;
      m_ready = ($urandom_range(0, 3) != 0);
      @(negedge aclk);
      if (m_valid && m_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL clamp_extra c=%0d: got word %h, expected none", c, m_data);
        end else begin
          e = sb.pop_front();
          if (m_data !== e.data || m_last !== e.last) begin
            errors++; $display("FAIL clamp_word %0d: got %h/%b, expected %h/%b", got, m_data, m_last, e.data, e.last);
          end
        end
        got++;
      end
      saw_done = (done === 1'b1);
    end
    checks++;
    if (!saw_done || got != DEPTH) begin
      errors++; $display("FAIL clamp_count: got done=%b words=%0d, expected done=1 words=%0d", saw_done, got, DEPTH);
    end
    checks++;
    if (en_count - issued0 != DEPTH || last_addr !== AW'(DEPTH - 1)) begin
      errors++; $display("FAIL clamp_reads: got %0d reads last_addr=%0d, expected %0d reads last_addr=%0d",
                         en_count - issued0, last_addr, DEPTH, DEPTH - 1);
    end
    sb.delete();
    m_ready = 1'b1;
    end_pass();
  endtask

  task automatic test_abort();
    int   got = 0;
    int   abort_c = -1;
    bit   saw_done = 0;
    exp_t e;
    push_expected(16);
    m_ready = 1'b1;
    start_pass(16);
    for (int c = 0; c < 40; c++) begin
      @(posedge aclk); #1;
      if (got == 5 && abort_c < 0) begin
        ps_done = 1'b0;
        m_ready = 1'b0;
        abort_c = c;
      end
      @(negedge aclk);
      if (m_valid && m_ready) begin
        e = sb.pop_front();
        checks++;
        if (m_data !== e.data) begin
          errors++; $display("FAIL abort_word %0d: got %h, expected %h", got, m_data, e.data);
        end
        got++;
      end
      if (abort_c >= 0 && c > abort_c) begin
        checks++;
        if ({m_valid, busy, done, bram_en} !== 4'b0000) begin
          errors++; $display("FAIL abort_idle c=%0d: got valid=%b busy=%b done=%b en=%b, expected all 0", c, m_valid, busy, done, bram_en);
        end
        if (c >= abort_c + 4) break;
      end
    end
    checks++;
    if (abort_c < 0) begin
      errors++; $display("FAIL abort_reached: got %0d handshakes, expected 5", got);
    end
    sb.delete();
    got = 0;
    push_expected(3);
    m_ready = 1'b1;
    start_pass(3);
    @(posedge aclk);
    @(negedge aclk);
    checks++;
    if (bram_en !== 1'b1 || bram_addr !== '0) begin
      errors++; $display("FAIL restart_addr: got en=%b addr=%0d, expected en=1 addr=0", bram_en, bram_addr);
    end
    for (int c = 0; c < 20 && !saw_done; c++) begin
      @(posedge aclk);
      @(negedge aclk);
      if (m_valid && m_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL restart_extra: got word %h, expected none", m_data);
        end else begin
          e = sb.pop_front();
          if (m_data !== e.data || m_last !== e.last) begin
            errors++; $display("FAIL restart_word %0d: got %h/%b, expected %h/%b", got, m_data, m_last, e.data, e.last);
          end
        end
        got++;
      end
      saw_done = (done === 1'b1);
    end
    checks++;
    if (!saw_done || got != 3) begin
      errors++; $display("FAIL restart_complete: got done=%b words=%0d, expected done=1 words=3", saw_done, got);
    end
    sb.delete();
    end_pass();
  endtask

  task automatic test_async_reset();
    int   got = 0;
    exp_t e;
    push_expected(16);
    m_ready = 1'b1;
    start_pass(16);
    for (int c = 0; c < 40 && got < 3; c++) begin
      @(negedge aclk);
      if (m_valid && m_ready) begin
        e = sb.pop_front();
        checks++;
        if (m_data !== e.data) begin
          errors++; $display("FAIL arst_word %0d: got %h, expected %h", got, m_data, e.data);
        end
        got++;
      end
    end
    checks++;
    if (got != 3) begin
      errors++; $display("FAIL arst_reached: got %0d words, expected 3", got);
    end
    #2 aresetn = 1'b0;
    #1;
    checks++;
    if ({bram_en, bram_we, bram_addr, m_data, m_valid, m_last, busy, done} !== '0) begin
      errors++; $display("FAIL arst_outputs: got en=%b addr=%h data=%h valid=%b last=%b busy=%b done=%b, expected all 0",
                         bram_en, bram_addr, m_data, m_valid, m_last, busy, done);
    end
    ps_done = 1'b0;
    sb.delete();
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge aclk);
      checks++;
      if ({m_valid, bram_en, busy, done} !== 4'b0000) begin
        errors++; $display("FAIL arst_stale k=%0d: got valid=%b en=%b busy=%b done=%b, expected all 0", k, m_valid, bram_en, busy, done);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(16'h0100 + i);
    test_reset();
    test_basic();
    test_backpressure();
    test_zero();
    test_clamp();
    test_abort();
    test_async_reset();
    checks++;
    if (bram_we !== 1'b0) begin
      errors++; $display("FAIL bram_we: got %b, expected 0", bram_we);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
